seq_detect_arb: RTL and testbench
=================================

SEQ_DETECT_ARB -- requirements
Module: seq_detect_arb

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req0_val, req1_val  input  1  requester has a valid stream bit.
REQ-005 SHALL have ports: req0_bit, req1_bit  input  1  serial stream bit.
REQ-006 SHALL have ports: req0_last, req1_last  input  1  bit is last of frame.
REQ-007 SHALL have ports: req0_rdy, req1_rdy  output  1  bit accepted when val&rdy.
REQ-008 SHALL have port: resp_val  output  1  frame result valid.
REQ-009 SHALL have port: resp_rdy  input  1  consumer accepts result.
REQ-010 SHALL have port: resp_id  output  1  requester owning result (0/1).
REQ-011 SHALL have port: resp_count  output  4  pattern matches in frame, saturating.
REQ-012 SHALL have port: resp_hit  output  1  resp_count != 0.
REQ-013 SHALL have port: state  output  4  shared detector state, one-hot.
REQ-014 SHALL have port: busy  output  1  controller not in IDLE.

Function
REQ-015 SHALL share one Moore detector: one-hot A=0001, B=0010, C=0100, D=1000; out=1 only in D.
REQ-016 Detector transitions on each accepted bit: A:0->A,1->B; B:0->C,1->B; C:0->A,1->D; D:0->C,1->B; illegal state -> 0000.
REQ-017 Detector SHALL hold state on cycles without an accepted bit.
REQ-018 Controller states: IDLE, STREAM, RESP.
REQ-019 IDLE: if any reqN_val, latch winner as owner, load detector A, clear count, go to STREAM next cycle; no rdy asserted in IDLE.
REQ-020 STREAM: only owner's rdy=1; non-owner rdy=0; owner val low -> wait indefinitely, no state change.
REQ-021 Each accepted bit whose next detector state is D SHALL increment count; count saturates at 15.
REQ-022 Accepted bit with last=1 SHALL move to RESP next cycle; count includes that bit's match.
REQ-023 RESP: resp_val=1, resp_id/resp_count/resp_hit stable until resp_val&resp_rdy, then IDLE next cycle.
REQ-024 No new grant in the same cycle as a resp handshake; minimum one IDLE cycle between frames.
REQ-025 Latency: last bit accepted in cycle N -> resp_val=1 in cycle N+1.
REQ-026 resp_val=0 outside RESP; resp_id/resp_count hold last values outside RESP.
REQ-027 Single-bit frame (first bit has last=1) SHALL be legal: count 0, RESP next cycle.

Reset
REQ-028 Reset low SHALL asynchronously force: controller IDLE, state=0001, count=0, resp_val=0, resp_id=0, resp_count=0, resp_hit=0, req0_rdy=req1_rdy=0, busy=0, round-robin pointer favouring req0.
REQ-029 Reset mid-frame or mid-RESP SHALL discard the frame and result; no response is produced.
REQ-030 Release SHALL be acted on at the first rising clk edge after reset goes high.

Configuration
REQ-031 Macro SEQ_DETECT_ARB_RR_EN defined: round-robin; after serving reqN, the other requester wins ties; pointer updates on resp handshake.
REQ-032 Macro SEQ_DETECT_ARB_RR_EN undefined: fixed priority; req0 always wins ties; pointer logic absent.

Verification
REQ-033 req0 sends 1,0,1,0,1(last) -> resp_id=0, resp_count=2, resp_hit=1, resp_val one cycle after last bit.
REQ-034 req1 sends 1,1,0,0(last) -> resp_id=1, resp_count=0, resp_hit=0; req0_rdy stays 0 throughout.
REQ-035 Both val high continuously, three frames -> RR_EN: resp_id 0,1,0; without macro: 0,0,0.
REQ-036 req0 sends 20 repeats of 1,0 then 1(last) -> resp_count=15 (saturated).
REQ-037 resp_rdy held low 5 cycles in RESP -> resp_val, resp_id, resp_count stable; no rdy asserted; IDLE one cycle after handshake.
REQ-038 Reset low mid-frame after 1,0 -> state=0001, busy=0, no resp_val; next frame 1,0,1(last) -> resp_count=1.

Source files
------------

// File: rtl/seq_detect_arb.sv
// rtl/seq_detect_arb.sv - two-requester serial pattern detector with shared Moore FSM and arbitration
// Optional feature macro: SEQ_DETECT_ARB_RR_EN (round-robin tie-break; fixed req0 priority when undefined)
module seq_detect_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_val,
  input  logic       req0_bit,
  input  logic       req0_last,
  output logic       req0_rdy,
  input  logic       req1_val,
  input  logic       req1_bit,
  input  logic       req1_last,
  output logic       req1_rdy,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic       resp_id,
  output logic [3:0] resp_count,
  output logic       resp_hit,
  output logic [3:0] state,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, STREAM, RESP} ctrl_t;

  localparam logic [3:0] DET_A = 4'b0001;
  localparam logic [3:0] DET_B = 4'b0010;
  localparam logic [3:0] DET_C = 4'b0100;
  localparam logic [3:0] DET_D = 4'b1000;

  ctrl_t      ctrl;
  ctrl_t      ctrl_nxt;
  logic       owner;
  logic       winner;
  logic [3:0] count;
  logic [3:0] count_inc;
  logic [3:0] det_nxt;
  logic       cur_val;
  logic       cur_bit;
  logic       cur_last;
  logic       accept;
  logic       any_val;

  assign any_val = req0_val | req1_val;

`ifdef SEQ_DETECT_ARB_RR_EN
  // ptr names the requester that wins a tie; 0 after reset so req0 is favoured first
  logic ptr;

  // Tie-break by pointer, otherwise the single valid requester wins
  always_comb begin
    winner = ~req0_val;
    if (req0_val && req1_val) winner = ptr;
  end

  // Hand the tie to the other requester once the current owner's result is consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         ptr <= 1'b0;
    else if (ctrl == RESP && resp_rdy)  ptr <= ~owner;
  end
`else
  // Fixed priority: req0 wins whenever it is valid
  always_comb begin
    winner = ~req0_val;
  end
`endif

  // Select the owner's stream lines and decide acceptance
  always_comb begin
    cur_val  = owner ? req1_val  : req0_val;
    cur_bit  = owner ? req1_bit  : req0_bit;
    cur_last = owner ? req1_last : req0_last;
    accept   = (ctrl == STREAM) && cur_val;
  end

  // Detector next state; any non-one-hot value collapses to all-zero
  always_comb begin
    det_nxt = 4'b0000;
    case (state)
      DET_A:   det_nxt = cur_bit ? DET_B : DET_A;
      DET_B:   det_nxt = cur_bit ? DET_B : DET_C;
      DET_C:   det_nxt = cur_bit ? DET_D : DET_A;
      DET_D:   det_nxt = cur_bit ? DET_B : DET_C;
      default: det_nxt = 4'b0000;
    endcase
  end

  // Match counter that saturates at 15
  always_comb begin
    count_inc = count;
    if (det_nxt == DET_D && count != 4'd15) count_inc = count + 4'd1;
  end

  // Controller state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ctrl <= IDLE;
    else        ctrl <= ctrl_nxt;
  end

  // Controller next state and handshake outputs
  always_comb begin
    ctrl_nxt = ctrl;
    req0_rdy = 1'b0;
    req1_rdy = 1'b0;
    resp_val = 1'b0;
    case (ctrl)
      IDLE: begin
        if (any_val) ctrl_nxt = STREAM;
      end
      STREAM: begin
        req0_rdy = ~owner;
        req1_rdy = owner;
        if (accept && cur_last) ctrl_nxt = RESP;
      end
      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) ctrl_nxt = IDLE;
      end
      default: ctrl_nxt = IDLE;
    endcase
  end

  // Grant latch, detector/count update and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= 1'b0;
      state      <= DET_A;
      count      <= 4'd0;
      resp_id    <= 1'b0;
      resp_count <= 4'd0;
    end else if (ctrl == IDLE && any_val) begin
      owner <= winner;
      state <= DET_A;
      count <= 4'd0;
    end else if (accept) begin
      state <= det_nxt;
      count <= count_inc;
      if (cur_last) begin
        resp_id    <= owner;
        resp_count <= count_inc;
      end
    end
  end

  assign resp_hit = (resp_count != 4'd0);
  assign busy     = (ctrl != IDLE);

endmodule

// File: tb/tb_seq_detect_arb.sv
// tb/tb_seq_detect_arb.sv - directed self-checking bench for seq_detect_arb
module tb_seq_detect_arb;

  logic       clk;
  logic       reset;
  logic       req0_val, req0_bit, req0_last, req0_rdy;
  logic       req1_val, req1_bit, req1_last, req1_rdy;
  logic       resp_val, resp_rdy, resp_id, resp_hit, busy;
  logic [3:0] resp_count, state;

  int n_tests = 0;
  int n_fail  = 0;

  logic       mon_r0;
  logic       r0_seen;
  logic [63:0] bits;
  logic        ids [3];
  int          got;
  logic        exp_ids [3];

  seq_detect_arb dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_bit(req0_bit), .req0_last(req0_last), .req0_rdy(req0_rdy),
    .req1_val(req1_val), .req1_bit(req1_bit), .req1_last(req1_last), .req1_rdy(req1_rdy),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_id(resp_id),
    .resp_count(resp_count), .resp_hit(resp_hit), .state(state), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mon_r0 && req0_rdy) r0_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Drive one frame on requester id; returns at the negedge after the final bit is accepted
  task automatic send_frame(input int id, input logic [63:0] fbits, input int n, input bit with_last);
    int t;
    int tmax;
    tmax = 0;
    for (int i = 0; i < n; i++) begin
      if (id == 0) begin
        req0_val = 1'b1; req0_bit = fbits[i]; req0_last = with_last && (i == n - 1);
      end else begin
        req1_val = 1'b1; req1_bit = fbits[i]; req1_last = with_last && (i == n - 1);
      end
      t = 0;
      while (!((id == 0) ? req0_rdy : req1_rdy) && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t > tmax) tmax = t;
      @(posedge clk);
      @(negedge clk);
    end
    req0_val = 1'b0; req0_last = 1'b0; req0_bit = 1'b0;
    req1_val = 1'b0; req1_last = 1'b0; req1_bit = 1'b0;
    check("rdy_wait_bound", (tmax < 50), 1);
  endtask

  // Check the pending result, then complete the handshake and confirm return to IDLE
  task automatic finish_resp(input string tag, input logic eid, input logic [3:0] ecount, input logic ehit);
    check({tag, "_resp_val"}, resp_val, 1);
    check({tag, "_resp_id"}, resp_id, eid);
    check({tag, "_resp_count"}, resp_count, ecount);
    check({tag, "_resp_hit"}, resp_hit, ehit);
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_resp_val"}, resp_val, 0);
  endtask

  initial begin
    reset = 1'b0;
    req0_val = 0; req0_bit = 0; req0_last = 0;
    req1_val = 0; req1_bit = 0; req1_last = 0;
    resp_rdy = 0; mon_r0 = 0; r0_seen = 0;
    repeat (2) @(negedge clk);

    check("rst_state", state, 4'b0001);
    check("rst_busy", busy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_count", resp_count, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_rdy", {req0_rdy, req1_rdy}, 0);

    reset = 1'b1;
    @(negedge clk);

    // req0: 1,0,1,0,1(last) -> two matches
    send_frame(0, 64'b10101, 5, 1);
    finish_resp("f1", 0, 4'd2, 1);

    // req1: 1,1,0,0(last) -> no match, req0 never ready
    mon_r0 = 1'b1; r0_seen = 1'b0;
    send_frame(1, 64'b0011, 4, 1);
    mon_r0 = 1'b0;
    check("f2_req0_rdy_never", r0_seen, 0);
    finish_resp("f2", 1, 4'd0, 0);

    // req0: twenty repeats of 1,0 then 1(last) -> 20 matches saturate at 15
    bits = '0;
    for (int k = 0; k < 20; k++) bits[2*k] = 1'b1;
    bits[40] = 1'b1;
    send_frame(0, bits, 41, 1);
    finish_resp("sat", 0, 4'd15, 1);

    // req1: 1,0,1(last), consumer stalls 5 cycles
    send_frame(1, 64'b101, 3, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_val", resp_val, 1);
      check("stall_resp_id", resp_id, 1);
      check("stall_resp_count", resp_count, 4'd1);
      check("stall_rdy", {req0_rdy, req1_rdy}, 0);
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
    check("stall_idle_busy", busy, 0);
    check("stall_idle_resp_val", resp_val, 0);
    check("stall_hold_count", resp_count, 4'd1);
    check("stall_hold_id", resp_id, 1);

    // Both requesters always valid, single-bit frames, consumer always ready
`ifdef SEQ_DETECT_ARB_RR_EN
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 0;
`else
    exp_ids[0] = 0; exp_ids[1] = 0; exp_ids[2] = 0;
`endif
    req0_val = 1; req0_bit = 1; req0_last = 1;
    req1_val = 1; req1_bit = 1; req1_last = 1;
    resp_rdy = 1;
    got = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (resp_val) begin
        ids[got] = resp_id;
        check("arb_single_bit_count", resp_count, 0);
        got++;
        @(negedge clk);
        check("arb_idle_gap", busy, 0);
      end else begin
        @(negedge clk);
      end
    end
    req0_val = 0; req0_bit = 0; req0_last = 0;
    req1_val = 0; req1_bit = 0; req1_last = 0;
    resp_rdy = 0;
    check("arb_resp_total", got, 3);
    for (int i = 0; i < 3; i++) check($sformatf("arb_id%0d", i), ids[i], exp_ids[i]);

    // Reset asserted mid-frame after 1,0 discards the frame
    @(negedge clk);
    send_frame(0, 64'b01, 2, 0);
    check("mid_busy_before_rst", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_state", state, 4'b0001);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_resp_val", resp_val, 0);
    check("mid_rst_rdy", {req0_rdy, req1_rdy}, 0);
    @(negedge clk);
    reset = 1'b1;
    r0_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_val) r0_seen = 1'b1;
    end
    check("mid_no_resp", r0_seen, 0);
    send_frame(0, 64'b101, 3, 1);
    finish_resp("post_rst", 0, 4'd1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
